// File: rtl/i2c_pkg.sv
// Shared types for the I2C requester arbiter slice.
// I2C_ADDR_W / I2C_WORD_W : slave address and register word widths.
// arb_state_t             : arbiter FSM states.
// i2c_req_t               : one requester's latched payload {addr, word}.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_WORD_W-1:0] word;
  } i2c_req_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at last+1 and wraps modulo NUM_REQ, so NUM_REQ need
// not be a power of two.
//   req  : request vector
//   last : index of the previous winner
//   pick : one-hot winner (zero when req is zero)
//   idx  : index of the winner (zero when req is zero)
module i2c_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  int               cand;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    // k = NUM_REQ revisits last itself, so a lone requester is re-granted.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      cidx = IDX_W'(cand);
      if (!found && req[cidx]) begin
        found      = 1'b1;
        pick[cidx] = 1'b1;
        idx        = cidx;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one strobe-paced I2C controller among
// NUM_REQ requesters.
//   clk, areset_n        : clock, asynchronous active-low reset
//   strobe_100kHz        : single-clk pacing strobe
//   req_valid            : level request per requester
//   req_slave_addr       : per-requester 7-bit slave address
//   req_word             : per-requester 16-bit register word
//   req_done / req_err   : one-clk completion / timeout pulse to the owner
//   grant                : one-hot owner while BUSY, else zero
//   busy                 : high in BUSY and GAP
//   ctrl_enable          : enable to i2c_ctrl
//   ctrl_slave_addr/word : latched payload to i2c_ctrl
//   ctrl_done            : register_done from i2c_ctrl, qualified by strobe
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int TIMEOUT_STROBES = 4096,
  parameter int GAP_STROBES     = 2
) (
  input  logic                                clk,
  input  logic                                areset_n,
  input  logic                                strobe_100kHz,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][I2C_ADDR_W-1:0]  req_slave_addr,
  input  logic [NUM_REQ-1:0][I2C_WORD_W-1:0]  req_word,
  output logic [NUM_REQ-1:0]                  req_done,
  output logic [NUM_REQ-1:0]                  req_err,
  output logic [NUM_REQ-1:0]                  grant,
  output logic                                busy,
  output logic                                ctrl_enable,
  output logic [I2C_ADDR_W-1:0]               ctrl_slave_addr,
  output logic [I2C_WORD_W-1:0]               ctrl_word,
  input  logic                                ctrl_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_STROBES + 1);
  localparam int GAP_W = 4;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_STROBES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_STROBES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
    return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  arb_state_t         state, state_n;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [IDX_W-1:0]   last_grant, last_n;
  logic [NUM_REQ-1:0] grant_n, done_n, err_n;
  logic               en_n;
  i2c_req_t           cur, cur_n;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;

  i2c_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_comb begin
    state_n   = state;
    to_cnt_n  = to_cnt;
    gap_cnt_n = gap_cnt;
    last_n    = last_grant;
    grant_n   = grant;
    en_n      = ctrl_enable;
    cur_n     = cur;
    done_n    = '0;
    err_n     = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_n    = BUSY;
          grant_n    = pick;
          last_n     = pick_idx;
          en_n       = 1'b1;
          cur_n.addr = req_slave_addr[pick_idx];
          cur_n.word = req_word[pick_idx];
          to_cnt_n   = '0;
        end
      end
      BUSY: begin
        // Done is tested first so it wins over a coincident timeout.
        if (strobe_100kHz) begin
          if (ctrl_done || (to_cnt == TO_LAST)) begin
            if (ctrl_done) done_n = grant;
            else           err_n  = grant;
            state_n   = GAP;
            grant_n   = '0;
            en_n      = 1'b0;
            gap_cnt_n = '0;
          end else begin
            to_cnt_n = to_sat_inc(to_cnt);
          end
        end
      end
      GAP: begin
        if (strobe_100kHz) begin
          if (gap_cnt == GAP_LAST) begin
            state_n   = IDLE;
            gap_cnt_n = '0;
          end else begin
            gap_cnt_n = gap_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        en_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= IDLE;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      last_grant  <= LAST_RST;
      grant       <= '0;
      ctrl_enable <= 1'b0;
      cur         <= '0;
      req_done    <= '0;
      req_err     <= '0;
    end else begin
      state       <= state_n;
      to_cnt      <= to_cnt_n;
      gap_cnt     <= gap_cnt_n;
      last_grant  <= last_n;
      grant       <= grant_n;
      ctrl_enable <= en_n;
      cur         <= cur_n;
      req_done    <= done_n;
      req_err     <= err_n;
    end
  end

  assign busy            = (state != IDLE);
  assign ctrl_slave_addr = cur.addr;
  assign ctrl_word       = cur.word;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter (NUM_REQ=2, TIMEOUT_STROBES=8,
// GAP_STROBES=2). The bench owns the strobe and ctrl_done, so every
// transaction is stepped strobe by strobe and bounded.
module tb_i2c_req_arbiter;

  localparam int N = 2;
  localparam int T = 8;
  localparam int G = 2;

  logic                 clk = 1'b0;
  logic                 areset_n = 1'b0;
  logic                 strobe_100kHz = 1'b0;
  logic                 ctrl_done = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0][6:0]    req_slave_addr = '0;
  logic [N-1:0][15:0]   req_word = '0;
  logic [N-1:0]         req_done, req_err, grant;
  logic                 busy, ctrl_enable;
  logic [6:0]           ctrl_slave_addr;
  logic [15:0]          ctrl_word;

  always #5 clk = ~clk;

  i2c_req_arbiter #(
    .NUM_REQ(N), .TIMEOUT_STROBES(T), .GAP_STROBES(G)
  ) dut (
    .clk(clk), .areset_n(areset_n), .strobe_100kHz(strobe_100kHz),
    .req_valid(req_valid), .req_slave_addr(req_slave_addr),
    .req_word(req_word), .req_done(req_done), .req_err(req_err),
    .grant(grant), .busy(busy), .ctrl_enable(ctrl_enable),
    .ctrl_slave_addr(ctrl_slave_addr), .ctrl_word(ctrl_word),
    .ctrl_done(ctrl_done)
  );

  int errors = 0;
  int checks = 0;
  int m_last = N - 1;

  // Observations gathered while a transaction runs.
  logic [N-1:0] o_grant, d_mask, e_mask, s1_grant;
  logic [6:0]   o_addr;
  logic [15:0]  o_word;
  logic         o_en, s1_busy, gap_seen;
  int d_cnt, e_cnt, pulse_at, wchg, oh_bad, gap_n, en_bad;

  // Reference round-robin: first requester after 'last', modulo N.
  function automatic int rr_model(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic sample();
    if (!$onehot0(grant) || !$onehot0(req_done | req_err)) oh_bad++;
    d_cnt += $countones(req_done);
    e_cnt += $countones(req_err);
    if (|req_done) d_mask = req_done;
    if (|req_err)  e_mask = req_err;
  endtask

  task automatic tick(input logic dn);
    strobe_100kHz = 1'b1;
    ctrl_done     = dn;
    @(negedge clk);
    strobe_100kHz = 1'b0;
    ctrl_done     = 1'b0;
    sample();
    s1_busy  = busy;
    s1_grant = grant;
    @(negedge clk);
    sample();
  endtask

  // Runs one transaction: observe the grant one clk after the call, then
  // strobe until a pulse (ctrl_done on strobe done_at, 0 = never), then
  // strobe through the gap until busy drops.
  task automatic run_txn(input int done_at, input int chg_at, input bit drop);
    d_cnt = 0; e_cnt = 0; d_mask = '0; e_mask = '0; pulse_at = 0;
    wchg = 0; oh_bad = 0; gap_n = 0; en_bad = 0; gap_seen = 1'b0;
    @(negedge clk);
    o_grant = grant; o_addr = ctrl_slave_addr; o_word = ctrl_word;
    o_en = ctrl_enable;
    sample();
    for (int s = 1; s <= T + 4 && pulse_at == 0; s++) begin
      if (s == chg_at) begin
        req_word[0] = 16'hABCD;
        req_valid   = '0;
      end
      tick(s == done_at);
      if (d_cnt + e_cnt > 0) begin
        pulse_at = s;
        gap_seen = s1_busy && (s1_grant == '0);
      end else if (ctrl_word !== o_word || ctrl_slave_addr !== o_addr ||
                   grant !== o_grant) begin
        wchg++;
      end
    end
    if (drop) req_valid = '0;
    while (gap_n < 10) begin
      if (ctrl_enable) en_bad++;
      tick(1'b0);
      gap_n++;
      if (!s1_busy) break;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({grant, req_done, req_err, busy, ctrl_enable} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0",
                         {grant, req_done, req_err, busy, ctrl_enable}); end
    checks++; if ({ctrl_slave_addr, ctrl_word} !== 23'h0) begin
      errors++; $display("FAIL reset_payload: got %h expected 0",
                         {ctrl_slave_addr, ctrl_word}); end
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || grant !== '0) begin
      errors++; $display("FAIL reset_idle: got busy=%b grant=%b expected 0 00",
                         busy, grant); end
  endtask

  task automatic test_contention();
    logic [N-1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    req_slave_addr[0] = 7'h21; req_word[0] = 16'hA000;
    req_slave_addr[1] = 7'h42; req_word[1] = 16'hB111;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      int own;
      own = rr_model(req_valid, m_last);
      run_txn(2, 0, t == 3);
      checks++; if (o_grant !== seq[t]) begin
        errors++; $display("FAIL cont_grant%0d: got %b expected %b", t, o_grant, seq[t]); end
      checks++; if (o_grant !== (2'b01 << own)) begin
        errors++; $display("FAIL cont_model%0d: got %b expected %b", t, o_grant, 2'b01 << own); end
      checks++; if (o_word !== req_word[own] || wchg != 0) begin
        errors++; $display("FAIL cont_word%0d: got %h (chg %0d) expected %h", t, o_word, wchg, req_word[own]); end
      checks++; if (d_mask !== seq[t] || d_cnt != 1 || e_cnt != 0) begin
        errors++; $display("FAIL cont_done%0d: got %b x%0d expected %b x1", t, d_mask, d_cnt, seq[t]); end
      m_last = own;
    end
  endtask

  task automatic test_single();
    req_slave_addr[0] = 7'h10; req_word[0] = 16'h3008;
    req_valid = 2'b01;
    run_txn(5, 0, 1);
    m_last = 0;
    checks++; if (o_grant !== 2'b01 || o_en !== 1'b1) begin
      errors++; $display("FAIL single_grant: got %b en=%b expected 01 en=1", o_grant, o_en); end
    checks++; if (o_word !== 16'h3008 || o_addr !== 7'h10) begin
      errors++; $display("FAIL single_payload: got %h/%h expected 10/3008", o_addr, o_word); end
    checks++; if (d_cnt != 1 || e_cnt != 0 || d_mask !== 2'b01 || pulse_at != 5) begin
      errors++; $display("FAIL single_done: got %0d/%0d mask %b at %0d expected 1/0 mask 01 at 5",
                         d_cnt, e_cnt, d_mask, pulse_at); end
    checks++; if (gap_n != G || en_bad != 0 || busy !== 1'b0 || !gap_seen) begin
      errors++; $display("FAIL single_gap: got %0d strobes en_bad %0d busy %b expected %0d 0 0",
                         gap_n, en_bad, busy, G); end
  endtask

  task automatic test_timeout();
    req_slave_addr[0] = 7'h33; req_word[0] = 16'h5555;
    req_valid = 2'b01;
    run_txn(0, 0, 1);
    m_last = 0;
    checks++; if (e_cnt != 1 || e_mask !== 2'b01 || pulse_at != T) begin
      errors++; $display("FAIL timeout_err: got %0d mask %b at %0d expected 1 mask 01 at %0d",
                         e_cnt, e_mask, pulse_at, T); end
    checks++; if (d_cnt != 0) begin
      errors++; $display("FAIL timeout_nodone: got %0d expected 0", d_cnt); end
    checks++; if (!gap_seen || gap_n != G || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_gap: got seen=%b n=%0d busy=%b expected 1 %0d 0",
                         gap_seen, gap_n, busy, G); end
  endtask

  task automatic test_boundary();
    req_valid = 2'b01;
    run_txn(T, 0, 1);
    m_last = 0;
    checks++; if (d_cnt != 1 || e_cnt != 0 || pulse_at != T) begin
      errors++; $display("FAIL boundary: got done %0d err %0d at %0d expected 1 0 at %0d",
                         d_cnt, e_cnt, pulse_at, T); end
  endtask

  task automatic test_payload();
    req_slave_addr[0] = 7'h11; req_word[0] = 16'h1234;
    req_valid = 2'b01;
    run_txn(4, 2, 1);
    m_last = 0;
    checks++; if (o_word !== 16'h1234 || wchg != 0 || ctrl_word !== 16'h1234) begin
      errors++; $display("FAIL payload_stable: got %h (chg %0d) expected 1234", ctrl_word, wchg); end
    checks++; if (d_cnt != 1 || d_mask !== 2'b01) begin
      errors++; $display("FAIL payload_done: got %0d mask %b expected 1 mask 01", d_cnt, d_mask); end
  endtask

  task automatic test_reset_mid_busy();
    req_valid = 2'b01;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin
      errors++; $display("FAIL rst_pre_grant: got %b expected 01", grant); end
    repeat (3) tick(1'b0);
    d_cnt = 0; e_cnt = 0;
    areset_n = 1'b0;
    #1;
    checks++; if ({grant, req_done, req_err, busy, ctrl_enable} !== '0 ||
                  {ctrl_slave_addr, ctrl_word} !== 23'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b %h expected 0",
                         {grant, req_done, req_err, busy, ctrl_enable},
                         {ctrl_slave_addr, ctrl_word}); end
    repeat (3) begin @(negedge clk); sample(); end
    checks++; if (d_cnt != 0 || e_cnt != 0) begin
      errors++; $display("FAIL rst_mid_pulse: got done %0d err %0d expected 0 0", d_cnt, e_cnt); end
    m_last = N - 1;
    req_valid = 2'b11;
    areset_n = 1'b1;
    run_txn(3, 0, 1);
    m_last = 0;
    checks++; if (o_grant !== 2'b01 || d_cnt != 1) begin
      errors++; $display("FAIL rst_first_grant: got %b done %0d expected 01 done 1", o_grant, d_cnt); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int own, da, exp_at;
      bit exp_done;
      for (int i = 0; i < N; i++) begin
        req_slave_addr[i] = 7'($urandom);
        req_word[i]       = 16'($urandom);
      end
      req_valid = N'($urandom_range(1, 3));
      da        = $urandom_range(0, T + 2);
      own       = rr_model(req_valid, m_last);
      exp_done  = (da >= 1 && da <= T);
      exp_at    = exp_done ? da : T;
      run_txn(da, 0, 1);
      checks++; if (o_grant !== (2'b01 << own) || o_word !== req_word[own] ||
                    o_addr !== req_slave_addr[own]) begin
        errors++; $display("FAIL rand%0d_grant: got %b %h/%h expected %b %h/%h", it,
                           o_grant, o_addr, o_word, 2'b01 << own, req_slave_addr[own], req_word[own]); end
      checks++; if (d_cnt != int'(exp_done) || e_cnt != int'(!exp_done) ||
                    pulse_at != exp_at || (d_mask | e_mask) !== (2'b01 << own)) begin
        errors++; $display("FAIL rand%0d_outcome: got d%0d e%0d at %0d mask %b expected d%0d e%0d at %0d",
                           it, d_cnt, e_cnt, pulse_at, d_mask | e_mask, exp_done, !exp_done, exp_at); end
      checks++; if (gap_n != G || oh_bad != 0 || wchg != 0) begin
        errors++; $display("FAIL rand%0d_misc: got gap %0d onehot_bad %0d chg %0d expected %0d 0 0",
                           it, gap_n, oh_bad, wchg, G); end
      m_last = own;
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_boundary();
    test_payload();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
Shares the single strobe-paced I2C controller (i2c_ctrl) among NUM_REQ requesters, for example the init-table sequencer and a runtime register writer. Each requester presents one slave address and one 16-bit register word per transaction. The arbiter grants requesters round-robin, latches the granted payload, drives the controller's enable/address/word inputs, and returns a done or error pulse to the granted requester. It sits between the requesters and i2c_ctrl inside i2c_top and replaces the direct init-counter hookup.

Parameters:
- NUM_REQ, 2: number of requesters. Range 2..8.
- TIMEOUT_STROBES, 4096: strobes in BUSY without ctrl_done before the transaction is aborted.
- GAP_STROBES, 2: strobes with ctrl_enable low between transactions. Range 1..15.

Ports:
- clk  in  1  system clock.
- areset_n  in  1  reset, asynchronous, active-low.
- strobe_100kHz  in  1  single-clk 100kHz strobe, synchronous to clk.
- req_valid  in  NUM_REQ  level request per requester; held until req_done or req_err.
- req_slave_addr  in  NUM_REQ x 7  per-requester 7-bit slave address.
- req_word  in  NUM_REQ x 16  per-requester register word.
- req_done  out  NUM_REQ  one-clk pulse: the granted transaction completed.
- req_err  out  NUM_REQ  one-clk pulse: the granted transaction timed out.
- grant  out  NUM_REQ  one-hot; the current owner while BUSY, otherwise zero.
- busy  out  1  high in BUSY and GAP.
- ctrl_enable  out  1  to i2c_ctrl enable.
- ctrl_slave_addr  out  7  to i2c_ctrl slave_address; latched.
- ctrl_word  out  16  to i2c_ctrl register_address; latched.
- ctrl_done  in  1  from i2c_ctrl register_done; sampled only when strobe_100kHz=1.

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=NUM_REQ-1, and all outputs 0. Counters clear. A transfer in flight is abandoned and no pulse is issued.
- States: IDLE, BUSY, GAP. The state machine is clk-driven. Only the ctrl_done sampling and the counters advance on strobe.
- IDLE, any req_valid bit set (no strobe needed):
  - Pick the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Next clk: latch ctrl_slave_addr and ctrl_word from the winner; set grant, last_grant, ctrl_enable=1, state=BUSY, to_cnt=0.
  - Latency is 1 clk from req_valid to grant.
- BUSY:
  - Payload and grant are frozen. Changes to req_* are ignored, including the owner dropping req_valid; the transfer still finishes and still pulses.
  - On strobe with ctrl_done=1: req_done[owner]=1 for one clk; grant=0, ctrl_enable=0, state=GAP, gap_cnt=0.
  - On strobe with ctrl_done=0: to_cnt++. When to_cnt reaches TIMEOUT_STROBES-1 on a strobe: req_err[owner]=1 for one clk, then the same exit as the done case.
  - If ctrl_done=1 on the same strobe that hits the timeout, done wins and no err pulse is issued.
- GAP: gap_cnt++ on each strobe. After GAP_STROBES strobes, go to IDLE. Requests arriving during GAP wait.
- The requester sees req_done or req_err in the same clk as the transition out of BUSY. It must drop or update req_valid on the following clk. If req_valid is still high in IDLE, it is treated as a new request.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- req_done and req_err are mutually exclusive and at most one bit is high per clk. grant is always one-hot or zero.
- Width rules:
  - to_cnt width is $clog2(TIMEOUT_STROBES+1) and it saturates, never wraps.
  - gap_cnt is 4 bits.
  - last_grant is $clog2(NUM_REQ) bits; the wrap is computed modulo NUM_REQ, not as a power of 2.

Decomposition:
- Package i2c_pkg holds:
  - I2C_ADDR_W=7 and I2C_WORD_W=16;
  - the arb_state_t enum {IDLE, BUSY, GAP};
  - typedef i2c_req_t {addr, word} for packed requester payloads.
- One sub-module, i2c_rr_pick: combinational round-robin picker.
  - Inputs: req vector and last index.
  - Outputs: one-hot pick and index.
  - Reusable for any future shared-bus arbiter.

Test Plan:
- Single request: req_valid=2'b01, addr=7'h10, word=16'h3008; ctrl_done asserted on the 5th strobe -> grant=01 one clk later, ctrl_word=16'h3008, req_done=01 pulses exactly once, ctrl_enable low for 2 strobes, busy drops.
- Contention: both requesters held high for 4 transactions -> grant sequence 01,10,01,10; each payload appears on ctrl_word only during its own grant.
- Timeout with TIMEOUT_STROBES=8 and ctrl_done never asserted -> req_err[0] pulses on the 8th strobe after grant, req_done stays 0, and the state passes through GAP to IDLE.
- Timeout boundary: ctrl_done=1 on exactly the 8th strobe -> req_done pulses, req_err stays 0.
- Payload stability: req_word changes from 16'h1234 to 16'hABCD mid-BUSY and the owner drops req_valid -> ctrl_word stays 16'h1234 and req_done still pulses.
- Reset mid-BUSY: areset_n low for 3 clks -> all outputs 0 immediately with no done or err pulse; after release with both requesting, the first grant goes to requester 0.
